fpu_issue_queue: RTL

- Buffers floating-point operation requests from decode/issue ahead of the combinational FPU datapath (multiply, floor, floor_to_int, compare).
- Carries a destination tag so writeback can match each FPU result to its request.
- Uses valid/ready handshakes on both sides and supports pipeline flush.
- Drops undefined opcodes at entry and reports each one on a separate illegal-op pulse.

---
 rtl/fpu_issue_queue.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fpu_issue_queue.sv
// Valid/ready issue queue for FPU requests, carrying a destination tag per entry.
// Optional same-cycle bypass into an empty queue when FPU_ISSUE_BYPASS_EN is defined.
module fpu_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_op,
    input  logic [31:0]            in_a,
    input  logic [31:0]            in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2:0]             out_op,
    output logic [31:0]            out_a,
    output logic [31:0]            out_b,
    output logic [TAG_W-1:0]       out_tag,
    output logic [$clog2(DEPTH):0] count,
    output logic                   illegal_valid,
    output logic [TAG_W-1:0]       illegal_tag
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [2:0]       op_q  [DEPTH];
    logic [31:0]      a_q   [DEPTH];
    logic [31:0]      b_q   [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             illegal_valid_q, illegal_valid_d;
    logic [TAG_W-1:0] illegal_tag_q, illegal_tag_d;

    logic queue_valid;
    logic push;
    logic push_legal;
    logic bypass;
    logic wr_en;
    logic pop;

    always_comb begin
        queue_valid = (count_q != '0);
        in_ready    = (count_q != CntW'(DEPTH));
        push        = in_valid && in_ready;
        push_legal  = push && !in_op[2];
`ifdef FPU_ISSUE_BYPASS_EN
        bypass      = !queue_valid && in_valid && !in_op[2] && !flush;
`else
        bypass      = 1'b0;
`endif
        out_valid   = queue_valid || bypass;
        if (bypass) begin
            out_op  = in_op;
            out_a   = in_a;
            out_b   = in_b;
            out_tag = in_tag;
        end else begin
            out_op  = op_q[rd_ptr_q];
            out_a   = a_q[rd_ptr_q];
            out_b   = b_q[rd_ptr_q];
            out_tag = tag_q[rd_ptr_q];
        end
        // A bypassed request consumed this cycle never occupies storage.
        wr_en = push_legal && !(bypass && out_ready) && !flush;
        pop   = queue_valid && out_ready && !flush;
    end

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        illegal_valid_d = push && in_op[2] && !flush;
        illegal_tag_d   = illegal_valid_d ? in_tag : illegal_tag_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + CntW'(wr_en) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            illegal_valid_q <= 1'b0;
            illegal_tag_q   <= '0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            illegal_valid_q <= illegal_valid_d;
            illegal_tag_q   <= illegal_tag_d;
        end
    end

    // Storage is never cleared; stale slots are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            op_q[wr_ptr_q]  <= in_op;
            a_q[wr_ptr_q]   <= in_a;
            b_q[wr_ptr_q]   <= in_b;
            tag_q[wr_ptr_q] <= in_tag;
        end
    end

    assign count         = count_q;
    assign illegal_valid = illegal_valid_q;
    assign illegal_tag   = illegal_tag_q;

endmodule
